// File: rtl/trg_cmd_arbiter.sv
// Round-robin arbiter sharing the single Data_Block command port (TRG_*) between two requesters.
// One command in flight; sequences enable pulse, busy rise/fall with timeout, returns completion.
module trg_cmd_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BUSY_WAIT  = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Req1_Valid,
    input  logic                  Req1_Write_Read,
    input  logic [ADDR_WIDTH-1:0] Req1_Addr,
    input  logic [DATA_WIDTH-1:0] Req1_Data,
    output logic                  Req1_Done,
    output logic                  Req1_Error,
    output logic [DATA_WIDTH-1:0] Req1_Rx_Data,
    input  logic                  Req2_Valid,
    input  logic                  Req2_Write_Read,
    input  logic [ADDR_WIDTH-1:0] Req2_Addr,
    input  logic [DATA_WIDTH-1:0] Req2_Data,
    output logic                  Req2_Done,
    output logic                  Req2_Error,
    output logic [DATA_WIDTH-1:0] Req2_Rx_Data,
    output logic                  TRG_enable_cmd,
    output logic                  TRG_write_read,
    output logic [ADDR_WIDTH-1:0] TRG_addr,
    output logic [DATA_WIDTH-1:0] TRG_data,
    input  logic                  TRG_busy,
    input  logic [DATA_WIDTH-1:0] TRG_rx_data,
    output logic                  Arb_Active,
    output logic                  Arb_Owner
);

    localparam int unsigned CNT_MAX = (TIMEOUT > BUSY_WAIT) ? TIMEOUT : BUSY_WAIT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BusyLast = CNT_W'(BUSY_WAIT - 1);
    localparam logic [CNT_W-1:0] TmoLast  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntSat   = CNT_W'(CNT_MAX);

    typedef enum logic [2:0] {StIdle, StIssue, StWaitBusy, StWaitDone, StRespond} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pref_q, pref_d;
    logic                  mask_q, mask_d;
    logic                  owner_q, owner_d;
    logic                  en_q, en_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done1_q, done1_d, err1_q, err1_d;
    logic                  done2_q, done2_d, err2_q, err2_d;
    logic [DATA_WIDTH-1:0] rx1_q, rx1_d, rx2_q, rx2_d;

    logic                  v1, v2, grant, finish, fin_err;
    logic [DATA_WIDTH-1:0] rx_sel;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pref_d  = pref_q;
        mask_d  = 1'b0;
        owner_d = owner_q;
        en_d    = 1'b0;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done1_d = 1'b0;
        err1_d  = 1'b0;
        rx1_d   = rx1_q;
        done2_d = 1'b0;
        err2_d  = 1'b0;
        rx2_d   = rx2_q;
        finish  = 1'b0;
        fin_err = 1'b0;
        grant   = 1'b0;
        rx_sel  = '0;
        // The requester just served is ignored for one IDLE cycle so a stale Valid is not re-granted.
        v1 = Req1_Valid & ~(mask_q & ~owner_q);
        v2 = Req2_Valid & ~(mask_q & owner_q);

        unique case (state_q)
            StIdle: begin
                if (v1 || v2) begin
                    grant   = (v1 && v2) ? pref_q : v2;
                    owner_d = grant;
                    wr_d    = grant ? Req2_Write_Read : Req1_Write_Read;
                    addr_d  = grant ? Req2_Addr : Req1_Addr;
                    data_d  = grant ? Req2_Data : Req1_Data;
                    en_d    = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (TRG_busy) begin
                    cnt_d   = '0;
                    state_d = StWaitDone;
                end else if (cnt_q == BusyLast) begin
                    finish = 1'b1;
                end else begin
                    cnt_d = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                // Busy falling on the timeout cycle still counts as a normal completion.
                if (!TRG_busy) begin
                    finish = 1'b1;
                end else if (cnt_q == TmoLast) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_d = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;
                end
            end
            StRespond: begin
                pref_d  = ~owner_q;
                mask_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (finish) begin
            state_d = StRespond;
            cnt_d   = '0;
            rx_sel  = fin_err ? '0 : TRG_rx_data;
            if (owner_q) begin
                done2_d = 1'b1;
                err2_d  = fin_err;
                rx2_d   = rx_sel;
            end else begin
                done1_d = 1'b1;
                err1_d  = fin_err;
                rx1_d   = rx_sel;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pref_q  <= 1'b0;
            mask_q  <= 1'b0;
            owner_q <= 1'b0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done1_q <= 1'b0;
            err1_q  <= 1'b0;
            rx1_q   <= '0;
            done2_q <= 1'b0;
            err2_q  <= 1'b0;
            rx2_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pref_q  <= pref_d;
            mask_q  <= mask_d;
            owner_q <= owner_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done1_q <= done1_d;
            err1_q  <= err1_d;
            rx1_q   <= rx1_d;
            done2_q <= done2_d;
            err2_q  <= err2_d;
            rx2_q   <= rx2_d;
        end
    end

    assign Req1_Done      = done1_q;
    assign Req1_Error     = err1_q;
    assign Req1_Rx_Data   = rx1_q;
    assign Req2_Done      = done2_q;
    assign Req2_Error     = err2_q;
    assign Req2_Rx_Data   = rx2_q;
    assign TRG_enable_cmd = en_q;
    assign TRG_write_read = wr_q;
    assign TRG_addr       = addr_q;
    assign TRG_data       = data_q;
    assign Arb_Active     = (state_q != StIdle);
    assign Arb_Owner      = owner_q;

endmodule

// File: tb/tb_trg_cmd_arbiter.sv
// Self-checking bench for trg_cmd_arbiter: directed scenarios plus randomized commands checked
// against a cycle-offset model of the handshake timing.
module tb_trg_cmd_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 4;
    localparam int unsigned TO = 16;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Req1_Valid, Req1_Write_Read, Req1_Done, Req1_Error;
    logic [AW-1:0] Req1_Addr;
    logic [DW-1:0] Req1_Data, Req1_Rx_Data;
    logic          Req2_Valid, Req2_Write_Read, Req2_Done, Req2_Error;
    logic [AW-1:0] Req2_Addr;
    logic [DW-1:0] Req2_Data, Req2_Rx_Data;
    logic          TRG_enable_cmd, TRG_write_read, TRG_busy, Arb_Active, Arb_Owner;
    logic [AW-1:0] TRG_addr;
    logic [DW-1:0] TRG_data, TRG_rx_data;

    int checks = 0;
    int errors = 0;
    int last_served = 2;  // 2 means requester 1 has priority next

    trg_cmd_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BUSY_WAIT (BW),
        .TIMEOUT   (TO)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Req1_Valid     (Req1_Valid),
        .Req1_Write_Read(Req1_Write_Read),
        .Req1_Addr      (Req1_Addr),
        .Req1_Data      (Req1_Data),
        .Req1_Done      (Req1_Done),
        .Req1_Error     (Req1_Error),
        .Req1_Rx_Data   (Req1_Rx_Data),
        .Req2_Valid     (Req2_Valid),
        .Req2_Write_Read(Req2_Write_Read),
        .Req2_Addr      (Req2_Addr),
        .Req2_Data      (Req2_Data),
        .Req2_Done      (Req2_Done),
        .Req2_Error     (Req2_Error),
        .Req2_Rx_Data   (Req2_Rx_Data),
        .TRG_enable_cmd (TRG_enable_cmd),
        .TRG_write_read (TRG_write_read),
        .TRG_addr       (TRG_addr),
        .TRG_data       (TRG_data),
        .TRG_busy       (TRG_busy),
        .TRG_rx_data    (TRG_rx_data),
        .Arb_Active     (Arb_Active),
        .Arb_Owner      (Arb_Owner)
    );

    always #5 Clock = ~Clock;

    // Called at a negedge of an IDLE cycle. Target raises busy 'dly' cycles after the enable pulse
    // for 'len' cycles (len 0: never). Expected Done offset from the enable pulse:
    //   no busy: 1+BW; busy len<=TO: dly+len+1; longer: dly+TO+1 with error.
    task automatic run_cmd(input int req, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input int dly, input int len,
                           input logic [DW-1:0] rxv);
        int e, n_en, exp_rel, rel;
        logic exp_err, own_done, oth_done, own_err;
        logic [DW-1:0] exp_rx, other_rx, own_rx, oth_rx;
        bit done_seen;
        if (len == 0) begin
            exp_rel = 1 + BW;
            exp_err = 1'b0;
        end else if (len <= TO) begin
            exp_rel = dly + len + 1;
            exp_err = 1'b0;
        end else begin
            exp_rel = dly + TO + 1;
            exp_err = 1'b1;
        end
        exp_rx   = exp_err ? '0 : rxv;
        other_rx = (req == 1) ? Req2_Rx_Data : Req1_Rx_Data;
        if (req == 1) begin
            Req1_Valid = 1'b1; Req1_Write_Read = wr; Req1_Addr = addr; Req1_Data = data;
        end else begin
            Req2_Valid = 1'b1; Req2_Write_Read = wr; Req2_Addr = addr; Req2_Data = data;
        end
        e = -1; n_en = 0; done_seen = 0;
        for (int c = 1; c <= int'(TO) + 40 && !done_seen; c++) begin
            @(negedge Clock);
            own_done = (req == 1) ? Req1_Done : Req2_Done;
            own_err  = (req == 1) ? Req1_Error : Req2_Error;
            own_rx   = (req == 1) ? Req1_Rx_Data : Req2_Rx_Data;
            oth_done = (req == 1) ? Req2_Done : Req1_Done;
            oth_rx   = (req == 1) ? Req2_Rx_Data : Req1_Rx_Data;
            if (TRG_enable_cmd === 1'b1) begin
                n_en++;
                if (e < 0) begin
                    e = c;
                    checks++;
                    if (c != 1 || TRG_addr !== addr || TRG_data !== data ||
                        TRG_write_read !== wr || Arb_Owner !== (req == 2)) begin
                        errors++;
                        $display("FAIL issue req%0d: cycle %0d addr %h data %h wr %b owner %b, want cycle 1 addr %h data %h wr %b owner %b",
                                 req, c, TRG_addr, TRG_data, TRG_write_read, Arb_Owner,
                                 addr, data, wr, (req == 2));
                    end
                end
            end
            rel = c - e;
            TRG_busy = (e >= 0 && len > 0 && rel >= dly && rel < dly + len);
            TRG_rx_data = TRG_busy ? DW'($urandom) : rxv;
            checks++;
            if (oth_done !== 1'b0) begin
                errors++;
                $display("FAIL other_done req%0d: non-owner Done %b at cycle %0d, want 0", req, oth_done, c);
            end
            if (own_done === 1'b1) begin
                done_seen = 1;
                checks++;
                if (e < 0 || rel != exp_rel || own_err !== exp_err || own_rx !== exp_rx) begin
                    errors++;
                    $display("FAIL done req%0d: offset %0d err %b rx %h, want offset %0d err %b rx %h",
                             req, rel, own_err, own_rx, exp_rel, exp_err, exp_rx);
                end
                checks++;
                if (n_en != 1 || oth_rx !== other_rx) begin
                    errors++;
                    $display("FAIL single_issue req%0d: enables %0d other_rx %h, want 1 and %h",
                             req, n_en, oth_rx, other_rx);
                end
                if (req == 1) Req1_Valid = 1'b0; else Req2_Valid = 1'b0;
                TRG_busy = 1'b0;
                last_served = req;
            end
        end
        if (!done_seen) begin
            checks++; errors++;
            $display("FAIL no_done req%0d: no Done within bound, want one at offset %0d", req, exp_rel);
            Req1_Valid = 1'b0; Req2_Valid = 1'b0; TRG_busy = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            checks++;
            if (TRG_enable_cmd !== 1'b0) begin
                errors++;
                $display("FAIL spurious_enable: enable %b after completion, want 0", TRG_enable_cmd);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        checks++;
        if ({Req1_Done, Req1_Error, Req1_Rx_Data, Req2_Done, Req2_Error, Req2_Rx_Data} !== '0) begin
            errors++;
            $display("FAIL reset_req_outputs: got %b/%b/%h %b/%b/%h, want all 0",
                     Req1_Done, Req1_Error, Req1_Rx_Data, Req2_Done, Req2_Error, Req2_Rx_Data);
        end
        checks++;
        if ({TRG_enable_cmd, TRG_write_read, TRG_addr, TRG_data, Arb_Active, Arb_Owner} !== '0) begin
            errors++;
            $display("FAIL reset_trg_outputs: en %b wr %b addr %h data %h act %b own %b, want all 0",
                     TRG_enable_cmd, TRG_write_read, TRG_addr, TRG_data, Arb_Active, Arb_Owner);
        end
        Reset = 1'b0;
        last_served = 2;
        @(negedge Clock);
    endtask

    task automatic test_single_write();
        run_cmd(1, 1'b1, 8'h12, 16'hBEEF, 3, 2, 16'h0000);
    endtask

    task automatic test_read();
        run_cmd(2, 1'b0, 8'h05, 16'h0000, 1, 3, 16'h1234);
        checks++;
        if (Req1_Done !== 1'b0 || Req1_Error !== 1'b0 || Req1_Rx_Data !== 16'h0000) begin
            errors++;
            $display("FAIL read_req1_quiet: done %b err %b rx %h, want 0 0 0000",
                     Req1_Done, Req1_Error, Req1_Rx_Data);
        end
    endtask

    task automatic test_timeout();
        run_cmd(1, 1'b0, 8'h40, 16'h0000, 2, TO + 4, 16'hFFFF);
        run_cmd(2, 1'b1, 8'h41, 16'h5555, 1, 2, 16'h0A0A);
        // Busy drops exactly on the last allowed cycle: completion, not timeout.
        run_cmd(1, 1'b0, 8'h42, 16'h0000, 2, TO, 16'h7E57);
    endtask

    task automatic test_no_busy();
        run_cmd(2, 1'b1, 8'h77, 16'h0F0F, 1, 0, 16'hABCD);
        run_cmd(1, 1'b0, 8'h78, 16'h0000, BW, 1, 16'h4321);
    endtask

    task automatic test_back_to_back();
        int exp_owner, e, n_done, last_done;
        exp_owner = (last_served == 1) ? 2 : 1;
        Req1_Write_Read = 1'b1; Req1_Addr = 8'hA1; Req1_Data = 16'h1111;
        Req2_Write_Read = 1'b0; Req2_Addr = 8'hB2; Req2_Data = 16'h2222;
        Req1_Valid = 1'b1; Req2_Valid = 1'b1;
        e = -1; n_done = 0; last_done = -1;
        for (int c = 1; c <= 200 && n_done < 6; c++) begin
            @(negedge Clock);
            if (TRG_enable_cmd === 1'b1) begin
                e = c;
                checks++;
                if (Arb_Owner !== (exp_owner == 2) ||
                    TRG_addr !== ((exp_owner == 1) ? 8'hA1 : 8'hB2)) begin
                    errors++;
                    $display("FAIL rr_grant #%0d: owner %b addr %h, want requester %0d",
                             n_done, Arb_Owner, TRG_addr, exp_owner);
                end
                checks++;
                if (c != ((last_done < 0) ? 1 : last_done + 2)) begin
                    errors++;
                    $display("FAIL rr_gap #%0d: enable at cycle %0d, last done %0d", n_done, c, last_done);
                end
            end
            TRG_busy = (e >= 0 && c == e + 1);
            TRG_rx_data = 16'h5A00 | 16'(n_done);
            if (Req1_Done === 1'b1 || Req2_Done === 1'b1) begin
                checks++;
                if (Req1_Done !== (exp_owner == 1) || Req2_Done !== (exp_owner == 2)) begin
                    errors++;
                    $display("FAIL rr_done #%0d: done1 %b done2 %b, want requester %0d",
                             n_done, Req1_Done, Req2_Done, exp_owner);
                end
                n_done++;
                last_done = c;
                last_served = exp_owner;
                exp_owner = 3 - exp_owner;
                e = -1;
                if (n_done == 6) begin
                    Req1_Valid = 1'b0; Req2_Valid = 1'b0;
                end
            end
        end
        checks++;
        if (n_done != 6) begin
            errors++;
            $display("FAIL rr_count: %0d completions, want 6", n_done);
        end
        Req1_Valid = 1'b0; Req2_Valid = 1'b0; TRG_busy = 1'b0;
        repeat (2) @(negedge Clock);
    endtask

    // Requester 1 alone keeps Valid high through Done: re-grant waits out one masked IDLE cycle.
    task automatic test_stale_valid();
        int e, n_done, last_done;
        Req1_Write_Read = 1'b0; Req1_Addr = 8'h3C; Req1_Data = 16'h0000;
        Req1_Valid = 1'b1;
        e = -1; n_done = 0; last_done = -1;
        for (int c = 1; c <= 60 && n_done < 2; c++) begin
            @(negedge Clock);
            if (TRG_enable_cmd === 1'b1) begin
                e = c;
                checks++;
                if (c != ((last_done < 0) ? 1 : last_done + 3)) begin
                    errors++;
                    $display("FAIL stale_mask: enable at cycle %0d, want %0d",
                             c, (last_done < 0) ? 1 : last_done + 3);
                end
            end
            TRG_busy = (e >= 0 && c == e + 1);
            TRG_rx_data = 16'h0101;
            if (Req1_Done === 1'b1) begin
                n_done++;
                last_done = c;
                e = -1;
                if (n_done == 2) Req1_Valid = 1'b0;
            end
        end
        checks++;
        if (n_done != 2) begin
            errors++;
            $display("FAIL stale_count: %0d completions, want 2", n_done);
        end
        last_served = 1;
        Req1_Valid = 1'b0; TRG_busy = 1'b0;
        repeat (2) @(negedge Clock);
    endtask

    task automatic test_reset_mid();
        int e;
        bit early_done;
        Req2_Write_Read = 1'b1; Req2_Addr = 8'h33; Req2_Data = 16'hC0DE;
        Req2_Valid = 1'b1;
        e = -1; early_done = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clock);
            if (TRG_enable_cmd === 1'b1 && e < 0) e = c;
            if (Req1_Done === 1'b1 || Req2_Done === 1'b1) early_done = 1;
            TRG_busy = (e >= 0 && c >= e + 1);
            if (e >= 0 && c == e + 4) begin
                Reset = 1'b1;
                break;
            end
        end
        @(negedge Clock);
        checks++;
        if (early_done || {Req1_Done, Req1_Error, Req1_Rx_Data, Req2_Done, Req2_Error,
                           Req2_Rx_Data} !== '0) begin
            errors++;
            $display("FAIL midreset_req: early %0d done %b/%b rx %h/%h, want no done and 0",
                     early_done, Req1_Done, Req2_Done, Req1_Rx_Data, Req2_Rx_Data);
        end
        checks++;
        if ({TRG_enable_cmd, TRG_write_read, TRG_addr, TRG_data, Arb_Active, Arb_Owner} !== '0) begin
            errors++;
            $display("FAIL midreset_trg: en %b wr %b addr %h data %h act %b own %b, want all 0",
                     TRG_enable_cmd, TRG_write_read, TRG_addr, TRG_data, Arb_Active, Arb_Owner);
        end
        Reset = 1'b0;
        TRG_busy = 1'b0;
        last_served = 2;
        run_cmd(2, 1'b1, 8'h33, 16'hC0DE, 1, 2, 16'h0000);
    endtask

    task automatic test_random();
        int req, dly, len, sel;
        for (int i = 0; i < 30; i++) begin
            req = int'($urandom_range(1, 2));
            dly = int'($urandom_range(1, BW));
            sel = int'($urandom_range(0, 9));
            if (sel == 0) len = 0;
            else if (sel == 1) len = int'(TO) + int'($urandom_range(0, 3));
            else len = int'($urandom_range(1, 8));
            run_cmd(req, 1'($urandom), AW'($urandom), DW'($urandom), dly, len, DW'($urandom));
        end
    endtask

    initial begin
        Reset = 1'b1;
        Req1_Valid = 1'b0; Req1_Write_Read = 1'b0; Req1_Addr = '0; Req1_Data = '0;
        Req2_Valid = 1'b0; Req2_Write_Read = 1'b0; Req2_Addr = '0; Req2_Data = '0;
        TRG_busy = 1'b0; TRG_rx_data = '0;
        test_reset();
        test_single_write();
        test_read();
        test_back_to_back();
        test_stale_valid();
        test_timeout();
        test_no_busy();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
